// File: rtl/im_fetch_sequencer.sv
// Item-memory fetch sequencer: walks two independent address streams
// (ports A and B) from a latched base with a latched stride, presenting each
// address on a valid/ready handshake until the requested item count is issued.
module im_fetch_sequencer #(
    parameter int  NumTotIm    = 1024,
    parameter int  CountWidth  = 16,
    localparam int ImAddrWidth = $clog2(NumTotIm)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   start_i,
    input  logic [CountWidth-1:0]  num_items_i,
    input  logic [ImAddrWidth-1:0] base_a_i,
    input  logic [ImAddrWidth-1:0] base_b_i,
    input  logic [ImAddrWidth-1:0] stride_a_i,
    input  logic [ImAddrWidth-1:0] stride_b_i,
    output logic [ImAddrWidth-1:0] lowdim_a_data_o,
    output logic [ImAddrWidth-1:0] lowdim_b_data_o,
    output logic                   im_a_data_valid_o,
    output logic                   im_b_data_valid_o,
    input  logic                   im_a_data_ready_i,
    input  logic                   im_b_data_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CountWidth-1:0]  issued_a_o,
    output logic [CountWidth-1:0]  issued_b_o
);

    localparam int NumPorts = 2;
    localparam logic [CountWidth-1:0] CntOne = {{(CountWidth-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CountWidth-1:0] num_items_reg;
    logic                  start_accept;

    // Per-port views of the A/B signals; index 0 is port A, index 1 is port B
    logic [NumPorts-1:0][ImAddrWidth-1:0] base_w;
    logic [NumPorts-1:0][ImAddrWidth-1:0] stride_w;
    logic [NumPorts-1:0][ImAddrWidth-1:0] addr_w;
    logic [NumPorts-1:0][CountWidth-1:0]  cnt_w;
    logic [NumPorts-1:0]                  ready_w;
    logic [NumPorts-1:0]                  valid_w;
    logic [NumPorts-1:0]                  port_done_next;

    assign base_w   = {base_b_i, base_a_i};
    assign stride_w = {stride_b_i, stride_a_i};
    assign ready_w  = {im_b_data_ready_i, im_a_data_ready_i};

    // A start is only honoured from IDLE, and a clear always wins over it
    assign start_accept = (state_reg == StIdle) && start_i && !clr_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= StIdle;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DONE follows the cycle in which both ports hold their full count
    always_comb begin
        state_next = state_reg;
        if (clr_i) begin
            state_next = StIdle;
        end else begin
            unique case (state_reg)
                StIdle: begin
                    if (start_i) begin
                        state_next = (num_items_i == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (&port_done_next) begin
                        state_next = StDone;
                    end
                end
                StDone: begin
                    state_next = StIdle;
                end
                default: begin
                    state_next = StIdle;
                end
            endcase
        end
    end

    // Status outputs decoded from the state
    always_comb begin
        busy_o = (state_reg != StIdle);
        done_o = (state_reg == StDone);
    end

    // Item count is captured once per run so a late start cannot change it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_items_reg <= '0;
        end else if (start_accept) begin
            num_items_reg <= num_items_i;
        end
    end

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
            logic [ImAddrWidth-1:0] addr_reg, addr_next;
            logic [ImAddrWidth-1:0] stride_reg, stride_next;
            logic [CountWidth-1:0]  cnt_reg, cnt_next;
            logic                   valid_reg, valid_next;
            logic                   xfer;

            assign xfer = (state_reg == StRun) && valid_reg && ready_w[gi];

            // Port datapath: advance on handshake; valid is registered so it never follows ready
            always_comb begin
                addr_next   = addr_reg;
                stride_next = stride_reg;
                cnt_next    = cnt_reg;
                valid_next  = 1'b0;
                if (clr_i) begin
                    addr_next  = '0;
                    cnt_next   = '0;
                    valid_next = 1'b0;
                end else if (start_accept) begin
                    addr_next   = base_w[gi];
                    stride_next = stride_w[gi];
                    cnt_next    = '0;
                    valid_next  = (num_items_i != '0);
                end else if (state_reg == StRun) begin
                    if (xfer) begin
                        cnt_next  = cnt_reg + CntOne;
                        addr_next = addr_reg + stride_reg;
                    end
                    valid_next = (cnt_next < num_items_reg);
                end
            end

            assign port_done_next[gi] = (cnt_next == num_items_reg);

            // Port registers
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    addr_reg   <= '0;
                    stride_reg <= '0;
                    cnt_reg    <= '0;
                    valid_reg  <= 1'b0;
                end else begin
                    addr_reg   <= addr_next;
                    stride_reg <= stride_next;
                    cnt_reg    <= cnt_next;
                    valid_reg  <= valid_next;
                end
            end

            assign addr_w[gi]  = addr_reg;
            assign cnt_w[gi]   = cnt_reg;
            assign valid_w[gi] = valid_reg;
        end
    endgenerate

    assign lowdim_a_data_o   = addr_w[0];
    assign lowdim_b_data_o   = addr_w[1];
    assign im_a_data_valid_o = valid_w[0];
    assign im_b_data_valid_o = valid_w[1];
    assign issued_a_o        = cnt_w[0];
    assign issued_b_o        = cnt_w[1];

endmodule

// File: tb/tb_im_fetch_sequencer.sv
// Scoreboard bench for im_fetch_sequencer: directed runs push the expected
// address streams and done cycle into queues; a negedge monitor pops and
// compares on every accepted address and every done pulse.
module tb_im_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic        start_i;
    logic [15:0] num_items_i;
    logic [9:0]  base_a_i, base_b_i, stride_a_i, stride_b_i;
    logic [9:0]  lowdim_a_data_o, lowdim_b_data_o;
    logic        im_a_data_valid_o, im_b_data_valid_o;
    logic        im_a_data_ready_i, im_b_data_ready_i;
    logic        busy_o, done_o;
    logic [15:0] issued_a_o, issued_b_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_a[$];
    int exp_b[$];
    int exp_done[$];

    im_fetch_sequencer #(.NumTotIm(1024), .CountWidth(16)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .clr_i             (clr_i),
        .start_i           (start_i),
        .num_items_i       (num_items_i),
        .base_a_i          (base_a_i),
        .base_b_i          (base_b_i),
        .stride_a_i        (stride_a_i),
        .stride_b_i        (stride_b_i),
        .lowdim_a_data_o   (lowdim_a_data_o),
        .lowdim_b_data_o   (lowdim_b_data_o),
        .im_a_data_valid_o (im_a_data_valid_o),
        .im_b_data_valid_o (im_b_data_valid_o),
        .im_a_data_ready_i (im_a_data_ready_i),
        .im_b_data_ready_i (im_b_data_ready_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .issued_a_o        (issued_a_o),
        .issued_b_o        (issued_b_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic config_run(input int n, input int ba, input int sa, input int bb, input int sb);
        num_items_i = 16'(n);
        base_a_i    = 10'(ba);
        stride_a_i  = 10'(sa);
        base_b_i    = 10'(bb);
        stride_b_i  = 10'(sb);
    endtask

    // Pulse start for one cycle; done_cyc < 0 means no done pulse is expected
    task automatic pulse_start(input int done_ofs);
        if (done_ofs >= 0) exp_done.push_back(cyc + 1 + done_ofs);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy_o && n < max_cycles) begin
            tick();
            n++;
        end
        chk("idle_timeout_busy", int'(busy_o), 0);
    endtask

    // Monitor: compares every accepted address and every done pulse
    initial begin
        bit pv_a = 0, pr_a = 0, pv_b = 0, pr_b = 0;
        int pa = 0, pb = 0;
        int e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && !clr_i) begin
                if (pv_a && !pr_a) begin
                    chk("a_stall_valid", int'(im_a_data_valid_o), 1);
                    chk("a_stall_addr", int'(lowdim_a_data_o), pa);
                end
                if (pv_b && !pr_b) begin
                    chk("b_stall_valid", int'(im_b_data_valid_o), 1);
                    chk("b_stall_addr", int'(lowdim_b_data_o), pb);
                end
                if (im_a_data_valid_o && im_a_data_ready_i) begin
                    e = (exp_a.size() > 0) ? exp_a.pop_front() : -1;
                    $display("cyc %0d port A addr %0d expected %0d", cyc, lowdim_a_data_o, e);
                    chk("a_addr", int'(lowdim_a_data_o), e);
                end
                if (im_b_data_valid_o && im_b_data_ready_i) begin
                    e = (exp_b.size() > 0) ? exp_b.pop_front() : -1;
                    $display("cyc %0d port B addr %0d expected %0d", cyc, lowdim_b_data_o, e);
                    chk("b_addr", int'(lowdim_b_data_o), e);
                end
                if (done_o) begin
                    e = (exp_done.size() > 0) ? exp_done.pop_front() : -1;
                    $display("cyc %0d done pulse expected at cyc %0d", cyc, e);
                    chk("done_cycle", cyc, e);
                end
            end
            pv_a = im_a_data_valid_o && rst_ni && !clr_i;
            pr_a = im_a_data_ready_i;
            pa   = int'(lowdim_a_data_o);
            pv_b = im_b_data_valid_o && rst_ni && !clr_i;
            pr_b = im_b_data_ready_i;
            pb   = int'(lowdim_b_data_o);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        rst_ni = 1'b0;
        clr_i = 1'b0;
        start_i = 1'b0;
        im_a_data_ready_i = 1'b0;
        im_b_data_ready_i = 1'b0;
        config_run(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset state
        chk("rst_valid_a", int'(im_a_data_valid_o), 0);
        chk("rst_valid_b", int'(im_b_data_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_addr_a", int'(lowdim_a_data_o), 0);
        chk("rst_issued_b", int'(issued_b_o), 0);
        rst_ni = 1'b1;
        tick();

        // Back-to-back run, both ports ready
        im_a_data_ready_i = 1'b1;
        im_b_data_ready_i = 1'b1;
        config_run(4, 10, 3, 0, 1);
        exp_a = {exp_a, 10, 13, 16, 19};
        exp_b = {exp_b, 0, 1, 2, 3};
        pulse_start(4);
        chk("first_valid_a", int'(im_a_data_valid_o), 1);
        chk("first_addr_a", int'(lowdim_a_data_o), 10);
        chk("busy_in_run", int'(busy_o), 1);
        wait_idle(20);
        chk("issued_a_final", int'(issued_a_o), 4);
        chk("issued_b_final", int'(issued_b_o), 4);
        tick();
        chk("issued_a_hold", int'(issued_a_o), 4);

        // Address wrap modulo 1024; B walks down with stride 1023
        config_run(4, 1022, 1, 5, 1023);
        exp_a = {exp_a, 1022, 1023, 0, 1};
        exp_b = {exp_b, 5, 4, 3, 2};
        pulse_start(4);
        wait_idle(20);

        // Port A stalls with ready 1,0,0,1,1; B finishes first
        config_run(3, 100, 2, 200, 5);
        exp_a = {exp_a, 100, 102, 104};
        exp_b = {exp_b, 200, 205, 210};
        pulse_start(5);
        im_a_data_ready_i = 1'b1;
        tick();
        im_a_data_ready_i = 1'b0;
        tick();
        tick();
        im_a_data_ready_i = 1'b1;
        chk("stall_b_valid_low", int'(im_b_data_valid_o), 0);
        chk("stall_a_valid_high", int'(im_a_data_valid_o), 1);
        chk("stall_a_addr", int'(lowdim_a_data_o), 102);
        chk("stall_issued_a", int'(issued_a_o), 1);
        chk("stall_issued_b", int'(issued_b_o), 3);
        chk("stall_busy", int'(busy_o), 1);
        wait_idle(20);
        chk("stall_issued_a_final", int'(issued_a_o), 3);

        // Zero items: DONE straight after start
        config_run(0, 1, 1, 2, 2);
        pulse_start(0);
        chk("zero_busy", int'(busy_o), 1);
        chk("zero_valid_a", int'(im_a_data_valid_o), 0);
        chk("zero_valid_b", int'(im_b_data_valid_o), 0);
        tick();
        chk("zero_busy_after", int'(busy_o), 0);

        // Start during RUN with a different config is ignored
        config_run(4, 7, 1, 50, 2);
        exp_a = {exp_a, 7, 8, 9, 10};
        exp_b = {exp_b, 50, 52, 54, 56};
        pulse_start(4);
        config_run(9, 300, 7, 400, 9);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_idle(30);
        chk("restart_issued_a", int'(issued_a_o), 4);
        chk("restart_issued_b", int'(issued_b_o), 4);

        // Clear after two of five transfers, with start asserted alongside
        config_run(5, 20, 4, 30, 1);
        exp_a = {exp_a, 20, 24};
        exp_b = {exp_b, 30, 31};
        pulse_start(-1);
        tick();
        tick();
        clr_i = 1'b1;
        start_i = 1'b1;
        tick();
        clr_i = 1'b0;
        start_i = 1'b0;
        chk("clr_valid_a", int'(im_a_data_valid_o), 0);
        chk("clr_valid_b", int'(im_b_data_valid_o), 0);
        chk("clr_issued_a", int'(issued_a_o), 0);
        chk("clr_busy", int'(busy_o), 0);
        chk("clr_done", int'(done_o), 0);
        repeat (3) tick();
        config_run(2, 20, 4, 30, 1);
        exp_a = {exp_a, 20, 24};
        exp_b = {exp_b, 30, 31};
        pulse_start(2);
        wait_idle(20);
        chk("after_clr_issued_a", int'(issued_a_o), 2);

        // Asynchronous reset mid-run abandons the run
        config_run(5, 40, 1, 60, 1);
        exp_a = {exp_a, 40, 41};
        exp_b = {exp_b, 60, 61};
        pulse_start(-1);
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("arst_valid_a", int'(im_a_data_valid_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_issued_b", int'(issued_b_o), 0);
        chk("arst_addr_a", int'(lowdim_a_data_o), 0);
        tick();
        rst_ni = 1'b1;
        repeat (4) tick();
        config_run(1, 3, 1, 4, 1);
        exp_a = {exp_a, 3};
        exp_b = {exp_b, 4};
        pulse_start(1);
        wait_idle(10);
        chk("post_rst_issued_a", int'(issued_a_o), 1);

        repeat (3) tick();
        chk("exp_a_left", exp_a.size(), 0);
        chk("exp_b_left", exp_b.size(), 0);
        chk("exp_done_left", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
